// File: rtl/fifo_stream_pkg.sv
// -----------------------------------------------------------------------------
// fifo_stream_pkg
// Shared types and constants for the FIFO stream writer.
//   skid_state_t : occupancy of the 2-entry skid buffer (EMPTY / ONE / TWO)
//   SKID_DEPTH   : number of beats the skid buffer can absorb
// -----------------------------------------------------------------------------
package fifo_stream_pkg;

  typedef enum logic [1:0] {
    SKID_EMPTY,
    SKID_ONE,
    SKID_TWO
  } skid_state_t;

  localparam int SKID_DEPTH = 2;

endpackage : fifo_stream_pkg

// File: rtl/fifo_stream_writer.sv
// -----------------------------------------------------------------------------
// fifo_stream_writer
// Upstream feeder for a FIFO write port. Takes a valid/ready byte stream,
// holds up to two beats in a skid buffer and writes them to the FIFO while
// prog_full is low. s_ready comes from registered state only, so prog_full
// never reaches the upstream ready path combinationally.
//
// Handshake: a beat transfers on a rising edge where s_valid & s_ready are
// both high; s_data/s_last are don't-care while s_valid is low. The FIFO side
// has no ready: a write happens on every edge where wr_en is high.
//
// Ports:
//   clk, rst   : clock (rising edge), asynchronous active-high reset
//   s_valid    : upstream beat valid
//   s_ready    : block can accept a beat this cycle
//   s_data     : upstream beat data
//   s_last     : last beat of a packet (counted only, not forwarded)
//   wr_en      : FIFO write strobe
//   din        : FIFO write data (head of the skid buffer)
//   prog_full  : FIFO programmable-full flag, blocks writes while high
//   word_cnt   : FIFO writes issued, wraps at 2^CNT_W
//   pkt_cnt    : accepted beats with s_last=1, wraps at 2^CNT_W
//   busy       : skid buffer holds at least one beat
//   state_dbg  : skid buffer state, for checkers and debug
// -----------------------------------------------------------------------------
module fifo_stream_writer
  import fifo_stream_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_last,
  output logic             wr_en,
  output logic [WIDTH-1:0] din,
  input  logic             prog_full,
  output logic [CNT_W-1:0] word_cnt,
  output logic [CNT_W-1:0] pkt_cnt,
  output logic             busy,
  output skid_state_t      state_dbg
);

  skid_state_t      state_q, state_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
  logic [CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;

  logic accept;
  logic pop;

  // Output decode: ready and write strobe depend on registered state only,
  // plus prog_full for the write side.
  assign s_ready   = (state_q != SKID_TWO);
  assign busy      = (state_q != SKID_EMPTY);
  assign wr_en     = (state_q != SKID_EMPTY) & ~prog_full;
  assign din       = head_q;
  assign word_cnt  = word_cnt_q;
  assign pkt_cnt   = pkt_cnt_q;
  assign state_dbg = state_q;

  assign accept = s_valid & s_ready;
  assign pop    = wr_en;

  // Head always holds the oldest beat, tail the newest.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    unique case (state_q)
      SKID_EMPTY: begin
        if (accept) begin
          head_d  = s_data;
          state_d = SKID_ONE;
        end
      end
      SKID_ONE: begin
        if (accept && pop) begin
          // Head leaves this edge and the new beat replaces it.
          head_d = s_data;
        end else if (accept) begin
          tail_d  = s_data;
          state_d = SKID_TWO;
        end else if (pop) begin
          state_d = SKID_EMPTY;
        end
      end
      SKID_TWO: begin
        if (pop) begin
          head_d  = tail_q;
          state_d = SKID_ONE;
        end
      end
      default: begin
        state_d = SKID_EMPTY;
      end
    endcase
  end

  always_comb begin
    word_cnt_d = word_cnt_q;
    pkt_cnt_d  = pkt_cnt_q;
    if (pop) begin
      word_cnt_d = word_cnt_q + 1'b1;
    end
    if (accept && s_last) begin
      pkt_cnt_d = pkt_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= SKID_EMPTY;
      head_q     <= '0;
      tail_q     <= '0;
      word_cnt_q <= '0;
      pkt_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      word_cnt_q <= word_cnt_d;
      pkt_cnt_q  <= pkt_cnt_d;
    end
  end

endmodule : fifo_stream_writer

// File: tb/tb_fifo_stream_writer.sv
// -----------------------------------------------------------------------------
// tb_fifo_stream_writer
// Self-checking bench for fifo_stream_writer. Accepted beats are pushed to an
// expected queue by the driver; every FIFO write pops and compares.
// -----------------------------------------------------------------------------
module tb_fifo_stream_writer;
  import fifo_stream_pkg::*;

  localparam int WIDTH = 8;
  localparam int CNT_W = 16;

  logic             clk;
  logic             rst;
  logic             s_valid;
  logic             s_ready;
  logic [WIDTH-1:0] s_data;
  logic             s_last;
  logic             wr_en;
  logic [WIDTH-1:0] din;
  logic             prog_full;
  logic [CNT_W-1:0] word_cnt;
  logic [CNT_W-1:0] pkt_cnt;
  logic             busy;
  skid_state_t      state_dbg;

  fifo_stream_writer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .s_last    (s_last),
    .wr_en     (wr_en),
    .din       (din),
    .prog_full (prog_full),
    .word_cnt  (word_cnt),
    .pkt_cnt   (pkt_cnt),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [WIDTH-1:0] exp_q[$];
  logic [CNT_W-1:0] exp_word_cnt = '0;
  logic [CNT_W-1:0] exp_pkt_cnt  = '0;
  int n_checks   = 0;
  int n_failures = 0;

  int run_len      = 0;
  int max_run      = 0;
  int first_acc    = -1;
  int first_wr     = -1;
  bit track_first  = 1'b0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Monitor: every FIFO write must carry the oldest outstanding beat.
  always @(negedge clk) begin
    if (!rst) begin
      if (wr_en) begin
        if (track_first && first_wr < 0) first_wr = cyc;
        run_len++;
        if (exp_q.size() == 0) begin
          check("write_without_beat", 32'(din), 32'hFFFF_FFFF);
        end else begin
          check("din_order", 32'(din), 32'(exp_q.pop_front()));
        end
      end else begin
        if (run_len > max_run) max_run = run_len;
        run_len = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_beat(input logic [WIDTH-1:0] d, input logic last);
    bit taken;
    taken   = 1'b0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (s_ready) begin
        taken = 1'b1;
        break;
      end
    end
    if (!taken) begin
      check("accept_timeout", 32'd0, 32'd1);
    end else begin
      if (track_first && first_acc < 0) first_acc = cyc;
      exp_q.push_back(d);
      exp_word_cnt = exp_word_cnt + 1'b1;
      if (last) exp_pkt_cnt = exp_pkt_cnt + 1'b1;
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_data  = $urandom_range(0, 255);
    s_last  = $urandom_range(0, 1);
  endtask

  task automatic drain(input string tag);
    bit idle;
    idle = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy) begin
        idle = 1'b1;
        break;
      end
    end
    @(negedge clk);
    check({tag, "_drained"}, 32'(idle), 32'd1);
    check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  bit stream_done;

  initial begin
    rst       = 1'b0;
    s_valid   = 1'b0;
    s_data    = '0;
    s_last    = 1'b0;
    prog_full = 1'b0;

    // Reset and idle values
    #1 rst = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("rst_s_ready", 32'(s_ready), 32'd1);
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_din", 32'(din), 32'd0);
    check("rst_word_cnt", 32'(word_cnt), 32'd0);
    check("rst_pkt_cnt", 32'(pkt_cnt), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("idle_s_ready", 32'(s_ready), 32'd1);
    check("idle_wr_en", 32'(wr_en), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_word_cnt", 32'(word_cnt), 32'd0);
    @(posedge clk);
    #1;

    // 16-beat back-to-back stream
    max_run     = 0;
    run_len     = 0;
    track_first = 1'b1;
    for (int i = 0; i < 16; i++) send_beat(8'(i), (i == 15));
    drain("stream16");
    track_first = 1'b0;
    check("stream16_run", 32'(max_run), 32'd16);
    check("stream16_latency", 32'(first_wr - first_acc), 32'd1);
    check("stream16_word_cnt", 32'(word_cnt), 32'd16);
    check("stream16_pkt_cnt", 32'(pkt_cnt), 32'd1);
    @(posedge clk);
    #1;

    // Backpressure: two beats absorbed, third stalls
    prog_full = 1'b1;
    send_beat(8'hA0, 1'b0);
    send_beat(8'hA1, 1'b0);
    s_valid = 1'b1;
    s_data  = 8'hA2;
    s_last  = 1'b1;
    @(negedge clk);
    check("pf_s_ready", 32'(s_ready), 32'd0);
    check("pf_wr_en", 32'(wr_en), 32'd0);
    check("pf_state", 32'(state_dbg), 32'(SKID_TWO));
    check("pf_din_head", 32'(din), 32'hA0);
    check("pf_word_cnt", 32'(word_cnt), 32'd16);
    @(posedge clk);
    #1;
    prog_full = 1'b0;
    send_beat(8'hA2, 1'b1);
    drain("pf_release");
    check("pf_word_cnt_after", 32'(word_cnt), 32'(exp_word_cnt));
    check("pf_pkt_cnt_after", 32'(pkt_cnt), 32'(exp_pkt_cnt));
    @(posedge clk);
    #1;

    // prog_full toggling during a 32-beat random stream
    stream_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 32; i++) send_beat(8'($urandom_range(0, 255)), (i == 31));
        stream_done = 1'b1;
      end
      begin
        while (!stream_done) begin
          @(posedge clk);
          #1;
          prog_full = ~prog_full;
        end
      end
    join
    prog_full = 1'b0;
    drain("toggle32");
    check("toggle32_word_cnt", 32'(word_cnt), 32'(exp_word_cnt));
    check("toggle32_word_cnt_abs", 32'(word_cnt), 32'd51);
    check("toggle32_pkt_cnt", 32'(pkt_cnt), 32'(exp_pkt_cnt));
    @(posedge clk);
    #1;

    // Reset while two beats are buffered
    prog_full = 1'b1;
    send_beat(8'h5A, 1'b0);
    send_beat(8'hC3, 1'b1);
    @(negedge clk);
    check("rst2_state_two", 32'(state_dbg), 32'(SKID_TWO));
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("rst2_async_s_ready", 32'(s_ready), 32'd1);
    check("rst2_async_busy", 32'(busy), 32'd0);
    check("rst2_async_wr_en", 32'(wr_en), 32'd0);
    check("rst2_async_din", 32'(din), 32'd0);
    check("rst2_async_word_cnt", 32'(word_cnt), 32'd0);
    exp_q.delete();
    exp_word_cnt = '0;
    exp_pkt_cnt  = '0;
    @(negedge clk);
    rst       = 1'b0;
    prog_full = 1'b0;
    repeat (4) @(negedge clk);
    check("rst2_no_write_busy", 32'(busy), 32'd0);
    check("rst2_word_cnt", 32'(word_cnt), 32'd0);
    check("rst2_pkt_cnt", 32'(pkt_cnt), 32'd0);
    @(posedge clk);
    #1;

    // Counter wrap from a preloaded value
    force dut.word_cnt_q = 16'hFFFE;
    #1;
    release dut.word_cnt_q;
    exp_word_cnt = 16'hFFFE;
    @(negedge clk);
    check("wrap_preload", 32'(word_cnt), 32'hFFFE);
    @(posedge clk);
    #1;
    send_beat(8'h11, 1'b0);
    drain("wrap1");
    check("wrap_ffff", 32'(word_cnt), 32'hFFFF);
    @(posedge clk);
    #1;
    send_beat(8'h22, 1'b0);
    drain("wrap2");
    check("wrap_0000", 32'(word_cnt), 32'h0000);
    @(posedge clk);
    #1;
    send_beat(8'h33, 1'b1);
    drain("wrap3");
    check("wrap_0001", 32'(word_cnt), 32'h0001);
    check("wrap_pkt_cnt", 32'(pkt_cnt), 32'(exp_pkt_cnt));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
    $finish;
  end

endmodule : tb_fifo_stream_writer
